// File: rtl/bus_arbiter_3_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_3_if
// Description : Handshake and select bundle between the three requesters,
//               the shared 8-bit bus mux, the consumer and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_3_if;
    logic [2:0] req;
    logic [2:0] last;
    logic       out_ready;
    logic [2:0] grant;
    logic       sel_first;
    logic       sel_second;
    logic       sel_third;
    logic       bus_valid;
    logic [2:0] beat_count;
    logic       xfer_done;

    // Arbiter side: owns the grant, selects and beat accounting
    modport master (
        input  req,
        input  last,
        input  out_ready,
        output grant,
        output sel_first,
        output sel_second,
        output sel_third,
        output bus_valid,
        output beat_count,
        output xfer_done
    );

    // Requester / consumer side
    modport slave (
        output req,
        output last,
        output out_ready,
        input  grant,
        input  sel_first,
        input  sel_second,
        input  sel_third,
        input  bus_valid,
        input  beat_count,
        input  xfer_done
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_3.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_3
// Description : Round-robin arbiter and burst sequencer for a 3-to-1 8-bit
//               bus mux. Drives one-hot mux selects, gates bus validity and
//               counts beats against out_ready, capping each grant at
//               MAX_BURST beats.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_3 #(
    parameter int MAX_BURST = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bus_arbiter_3_if.master  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Beat index at which a grant is force-terminated
    localparam logic [2:0] c_max_beat = 3'(MAX_BURST - 1);

    state_t     r_state;
    logic [2:0] r_grant;
    logic [1:0] r_ptr;
    logic [2:0] r_beat_count;

    logic       w_valid;
    logic       w_beat;
    logic       w_last;
    logic       w_term;
    logic       w_abandon;
    logic       w_release;
    logic [1:0] w_gidx;
    logic [2:0] w_arb_idle;
    logic [2:0] w_arb_rel;

    // Round-robin pick: search begins one past the pointer and wraps
    function automatic logic [2:0] arb(input logic [2:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        res = 3'b000;
        case (ptr)
            2'd0: begin
                if      (r[1]) res = 3'b010;
                else if (r[2]) res = 3'b100;
                else if (r[0]) res = 3'b001;
            end
            2'd1: begin
                if      (r[2]) res = 3'b100;
                else if (r[0]) res = 3'b001;
                else if (r[1]) res = 3'b010;
            end
            default: begin
                if      (r[0]) res = 3'b001;
                else if (r[1]) res = 3'b010;
                else if (r[2]) res = 3'b100;
            end
        endcase
        return res;
    endfunction

    // Index of the one-hot grant; only consulted while a grant is held
    function automatic logic [1:0] onehot_idx(input logic [2:0] g);
        logic [1:0] idx;
        idx = 2'd0;
        if (g[1]) idx = 2'd1;
        if (g[2]) idx = 2'd2;
        return idx;
    endfunction

    assign w_valid    = |(r_grant & bus.req);
    assign w_beat     = w_valid & bus.out_ready;
    assign w_last     = |(r_grant & bus.last);
    assign w_term     = w_beat & (w_last | (r_beat_count == c_max_beat));
    // Granted requester withdrew its request: drop the grant without a beat
    assign w_abandon  = (r_state == BUSY) & ~w_valid;
    assign w_release  = w_term | w_abandon;
    assign w_gidx     = onehot_idx(r_grant);
    assign w_arb_idle = arb(bus.req, r_ptr);
    // On release the pointer moves to the outgoing owner in the same edge
    assign w_arb_rel  = arb(bus.req, w_gidx);

    // Grant FSM: arbitration, burst counting and release/re-arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 3'b000;
            r_ptr        <= 2'd2;
            r_beat_count <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_grant      <= w_arb_idle;
                        r_state      <= BUSY;
                        r_beat_count <= 3'd0;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_ptr        <= w_gidx;
                        r_beat_count <= 3'd0;
                        r_grant      <= w_arb_rel;
                        r_state      <= (w_arb_rel != 3'b000) ? BUSY : IDLE;
                    end else if (w_beat) begin
                        r_beat_count <= r_beat_count + 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 3'b000;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.sel_first  = r_grant[0];
    assign bus.sel_second = r_grant[1];
    assign bus.sel_third  = r_grant[2];
    assign bus.bus_valid  = w_valid;
    assign bus.beat_count = r_beat_count;
    assign bus.xfer_done  = w_term;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_3
// Description : Directed self-checking bench for bus_arbiter_3 (MAX_BURST=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_3;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    bus_arbiter_3_if bus ();

    bus_arbiter_3 #(.MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] g, input int bc,
                             input logic v, input logic xd);
        check({tag, ".grant"},  int'(bus.grant), int'(g));
        check({tag, ".sel"},    int'({bus.sel_third, bus.sel_second, bus.sel_first}), int'(g));
        check({tag, ".bc"},     int'(bus.beat_count), bc);
        check({tag, ".valid"},  int'(bus.bus_valid), int'(v));
        check({tag, ".xdone"},  int'(bus.xfer_done), int'(xd));
    endtask

    // Absolute run-time bound
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    logic [2:0] exp_rot [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req = 3'b111;
        bus.last = 3'b000;
        bus.out_ready = 1'b0;

        // 1. Reset holds everything at zero even with all requests up
        #1;
        check_all("rst0", 3'b000, 0, 1'b0, 1'b0);
        tick();
        check_all("rst1", 3'b000, 0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_all("rst_rel", 3'b000, 0, 1'b0, 1'b0);
        tick();
        check_all("first_grant", 3'b001, 0, 1'b1, 1'b0);
        bus.req = 3'b000;
        #1;
        check("drop.valid", int'(bus.bus_valid), 0);
        tick();
        check_all("idle_after_drop", 3'b000, 0, 1'b0, 1'b0);

        // 2. Single burst from requester 1, last on third beat (ptr=0 now)
        bus.req = 3'b010;
        bus.out_ready = 1'b1;
        tick();
        check_all("sb.b0", 3'b010, 0, 1'b1, 1'b0);
        tick();
        check_all("sb.b1", 3'b010, 1, 1'b1, 1'b0);
        tick();
        bus.last = 3'b010;
        #1;
        check_all("sb.b2", 3'b010, 2, 1'b1, 1'b1);
        // foreign last bits are ignored
        bus.last = 3'b101;
        #1;
        check("sb.foreign_last", int'(bus.xfer_done), 0);
        bus.last = 3'b010;
        tick();
        // sole requester re-wins with no bubble
        check_all("sb.rewin", 3'b010, 0, 1'b1, 1'b1);
        bus.req = 3'b000;
        bus.last = 3'b000;
        #1;
        check("sb.abandon_xd", int'(bus.xfer_done), 0);
        tick();
        check_all("sb.idle", 3'b000, 0, 1'b0, 1'b0);

        // 3. Fairness: pointer sits at 1, so rotation begins at requester 2
        exp_rot[0] = 3'b100;
        exp_rot[1] = 3'b001;
        exp_rot[2] = 3'b010;
        exp_rot[3] = 3'b100;
        bus.req = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) begin
                check_all($sformatf("rr%0d.b%0d", k, b), exp_rot[k], b, 1'b1, (b == 3));
                tick();
            end
        end

        // 4. Backpressure on requester 0
        check_all("bp.b0", 3'b001, 0, 1'b1, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        #1;
        check_all("bp.stall0", 3'b001, 1, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_all($sformatf("bp.stall%0d", i), 3'b001, 1, 1'b1, 1'b0);
        end
        bus.out_ready = 1'b1;
        tick();
        check_all("bp.b2", 3'b001, 2, 1'b1, 1'b0);
        tick();
        check_all("bp.b3", 3'b001, 3, 1'b1, 1'b1);
        tick();
        check_all("bp.next", 3'b010, 0, 1'b1, 1'b0);

        // 5. Abandon by requester 2 at beat_count 2
        for (int b = 1; b < 4; b++) begin
            tick();
            check("ab.pre_bc", int'(bus.beat_count), b);
        end
        tick();
        check_all("ab.g2", 3'b100, 0, 1'b1, 1'b0);
        tick();
        tick();
        check_all("ab.bc2", 3'b100, 2, 1'b1, 1'b0);
        bus.req = 3'b001;
        #1;
        check_all("ab.drop", 3'b100, 2, 1'b0, 1'b0);
        tick();
        check_all("ab.new", 3'b001, 0, 1'b1, 1'b0);

        // 6. Asynchronous reset between edges during grant 010
        bus.req = 3'b010;
        tick();
        check_all("ar.g1", 3'b010, 0, 1'b1, 1'b0);
        tick();
        check("ar.bc1", int'(bus.beat_count), 1);
        rst = 1'b1;
        #1;
        check_all("ar.async", 3'b000, 0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.req = 3'b101;
        #1;
        check_all("ar.held", 3'b000, 0, 1'b0, 1'b0);
        tick();
        check_all("ar.first", 3'b001, 0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
